// File: rtl/ascon_stream_host.sv
// Host-side byte-stream driver for the Ascon-128 AEAD core serial port:
// streams key, nonce and plaintext bytes to the core, then collects its output bytes.
`timescale 1ns/1ps
module ascon_stream_host #(
    parameter int PT_BYTES   = 8,
    parameter int TAG_BYTES  = 16,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic [63:0]  pt,
    output logic         core_start,
    output logic         core_valid,
    output logic [7:0]   core_data,
    input  logic         core_ready,
    input  logic         core_done,
    input  logic [7:0]   core_byte,
    output logic [127:0] result,
    output logic [4:0]   result_cnt,
    output logic         result_valid,
    output logic         err_timeout,
    output logic         busy
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_KEY     = 3'd2;
    localparam logic [2:0] S_NONCE   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;
    localparam logic [2:0] S_PT      = 3'd5;
    localparam logic [2:0] S_COLLECT = 3'd6;
    localparam logic [2:0] S_FIN     = 3'd7;

    logic [2:0]   state;
    logic [127:0] key_sr;
    logic [127:0] nonce_sr;
    logic [127:0] pt_sr;
    logic [4:0]   cnt;
    logic [7:0]   tmo;
    logic         capture;

    assign capture = core_ready && (result_cnt < 5'(TAG_BYTES));

    // FSM; outputs are registered for the cycle that the next state describes
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            key_sr       <= 128'h0;
            nonce_sr     <= 128'h0;
            pt_sr        <= 128'h0;
            cnt          <= 5'd0;
            tmo          <= 8'd0;
            cmd_ready    <= 1'b1;
            core_start   <= 1'b0;
            core_valid   <= 1'b0;
            core_data    <= 8'h00;
            result       <= 128'h0;
            result_cnt   <= 5'd0;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            core_start   <= 1'b0;
            result_valid <= 1'b0;
            err_timeout  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        key_sr     <= key;
                        nonce_sr   <= nonce;
                        pt_sr      <= {64'h0, pt};
                        result     <= 128'h0;
                        result_cnt <= 5'd0;
                        state      <= S_START;
                        core_start <= 1'b1;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_START: begin
                    state      <= S_KEY;
                    cnt        <= 5'd0;
                    core_valid <= 1'b1;
                    core_data  <= key_sr[7:0];
                    key_sr     <= {8'h00, key_sr[127:8]};
                end
                S_KEY: begin
                    if (cnt == 5'd15) begin
                        state     <= S_NONCE;
                        cnt       <= 5'd0;
                        core_data <= nonce_sr[7:0];
                        nonce_sr  <= {8'h00, nonce_sr[127:8]};
                    end else begin
                        cnt       <= cnt + 5'd1;
                        core_data <= key_sr[7:0];
                        key_sr    <= {8'h00, key_sr[127:8]};
                    end
                end
                S_NONCE: begin
                    if (cnt != 5'd15) begin
                        cnt       <= cnt + 5'd1;
                        core_data <= nonce_sr[7:0];
                        nonce_sr  <= {8'h00, nonce_sr[127:8]};
                    end else if (GAP_CYCLES == 0) begin
                        state     <= S_PT;
                        cnt       <= 5'd0;
                        core_data <= pt_sr[7:0];
                        pt_sr     <= {8'h00, pt_sr[127:8]};
                    end else begin
                        state      <= S_GAP;
                        cnt        <= 5'd0;
                        core_valid <= 1'b0;
                        core_data  <= 8'h00;
                    end
                end
                S_GAP: begin
                    if (cnt == 5'(GAP_CYCLES - 1)) begin
                        state      <= S_PT;
                        cnt        <= 5'd0;
                        core_valid <= 1'b1;
                        core_data  <= pt_sr[7:0];
                        pt_sr      <= {8'h00, pt_sr[127:8]};
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_PT: begin
                    if (cnt == 5'(PT_BYTES - 1)) begin
                        state      <= S_COLLECT;
                        tmo        <= 8'd0;
                        core_valid <= 1'b0;
                        core_data  <= 8'h00;
                    end else begin
                        cnt       <= cnt + 5'd1;
                        core_data <= pt_sr[7:0];
                        pt_sr     <= {8'h00, pt_sr[127:8]};
                    end
                end
                S_COLLECT: begin
                    // a byte arriving together with core_done is still kept
                    if (capture) begin
                        result[{result_cnt[3:0], 3'b000} +: 8] <= core_byte;
                        result_cnt <= result_cnt + 5'd1;
                    end
                    if (core_done) begin
                        state        <= S_FIN;
                        result_valid <= 1'b1;
                    end else if (tmo == 8'(TIMEOUT - 1)) begin
                        state       <= S_IDLE;
                        err_timeout <= 1'b1;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    cmd_ready  <= 1'b1;
                    busy       <= 1'b0;
                    core_valid <= 1'b0;
                    core_data  <= 8'h00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_stream_host.sv
// Randomized scoreboard bench for ascon_stream_host: a driver queues the expected
// output events per command and an independent monitor compares every DUT output event.
`timescale 1ns/1ps
module tb_ascon_stream_host;
    localparam int PT_B = 8;
    localparam int GAP  = 2;
    localparam int TMO  = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [127:0] key;
    logic [127:0] nonce;
    logic [63:0]  pt;
    logic         core_start;
    logic         core_valid;
    logic [7:0]   core_data;
    logic         core_ready;
    logic         core_done;
    logic [7:0]   core_byte;
    logic [127:0] result;
    logic [4:0]   result_cnt;
    logic         result_valid;
    logic         err_timeout;
    logic         busy;

    ascon_stream_host #(.PT_BYTES(PT_B), .TAG_BYTES(16), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .key(key), .nonce(nonce), .pt(pt),
        .core_start(core_start), .core_valid(core_valid), .core_data(core_data),
        .core_ready(core_ready), .core_done(core_done), .core_byte(core_byte),
        .result(result), .result_cnt(result_cnt), .result_valid(result_valid),
        .err_timeout(err_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 start strobe, 1 streamed byte, 2 result_valid, 3 err_timeout
    typedef struct {
        int           kind;
        int           at;
        logic [7:0]   data;
        logic [127:0] res;
        logic [4:0]   cnt;
        logic         bsy;
        logic         rdy;
    } ev_t;

    ev_t        expq[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] src [0:31];
    ev_t        mon_e;
    int         mon_k;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every active output cycle must match the next queued event
    always @(negedge clk) begin
        if (core_start || core_valid || result_valid || err_timeout) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event at cycle %0d: start=%b valid=%b rv=%b to=%b expected none",
                         cyc, core_start, core_valid, result_valid, err_timeout);
            end else begin
                mon_e = expq.pop_front();
                mon_k = core_start ? 0 : (core_valid ? 1 : (result_valid ? 2 : 3));
                check("event_kind", 128'(mon_k), 128'(mon_e.kind));
                check("event_cycle", 128'(cyc), 128'(mon_e.at));
                check("core_data", 128'(core_data), 128'(mon_e.data));
                check("busy", 128'(busy), 128'(mon_e.bsy));
                check("cmd_ready", 128'(cmd_ready), 128'(mon_e.rdy));
                if (mon_e.kind >= 2) begin
                    check("result", result, mon_e.res);
                    check("result_cnt", 128'(result_cnt), 128'(mon_e.cnt));
                end
            end
        end else begin
            check("idle_core_data", 128'(core_data), 128'h0);
        end
    end

    // Expected start strobe and byte stream for a command accepted in cycle a
    task automatic push_stream(input int a, input logic [127:0] k, input logic [127:0] n,
                               input logic [63:0] p, input int limit);
        ev_t          e;
        logic [127:0] pw;
        pw    = {64'h0, p};
        e.res = 128'h0;
        e.cnt = 5'd0;
        e.bsy = 1'b1;
        e.rdy = 1'b0;
        e.kind = 0; e.at = a + 1; e.data = 8'h00;
        if (e.at - a <= limit) expq.push_back(e);
        e.kind = 1;
        for (int i = 0; i < 16; i++) begin
            e.at = a + 2 + i; e.data = k[8*i +: 8];
            if (e.at - a <= limit) expq.push_back(e);
        end
        for (int i = 0; i < 16; i++) begin
            e.at = a + 18 + i; e.data = n[8*i +: 8];
            if (e.at - a <= limit) expq.push_back(e);
        end
        for (int i = 0; i < PT_B; i++) begin
            e.at = a + 34 + GAP + i; e.data = pw[8*i +: 8];
            if (e.at - a <= limit) expq.push_back(e);
        end
    endtask

    // One full command; mode 0: done with last byte, 1: done one cycle later, 2: never
    task automatic run_cmd(input logic [127:0] k, input logic [127:0] n, input logic [63:0] p,
                           input int nrdy, input int delay, input int mode);
        int           a, base, done_at, end_at, kept, c;
        ev_t          e;
        logic [127:0] r;
        a = cyc;
        check("cmd_ready_idle", 128'(cmd_ready), 128'h1);
        check("busy_idle", 128'(busy), 128'h0);
        key = k; nonce = n; pt = p; cmd_valid = 1'b1;
        push_stream(a, k, n, p, 1000);
        base    = a + 36 + PT_B + delay;
        done_at = (mode == 2) ? -1 : base + nrdy - ((mode == 0) ? 1 : 0);
        kept    = (nrdy > 16) ? 16 : nrdy;
        r = 128'h0;
        for (int i = 0; i < kept; i++) r[8*i +: 8] = src[i];
        e.data = 8'h00; e.res = r; e.cnt = 5'(kept);
        if (mode == 2) begin
            e.kind = 3; e.at = a + 36 + PT_B + TMO; e.bsy = 1'b0; e.rdy = 1'b1;
            end_at = e.at;
        end else begin
            e.kind = 2; e.at = done_at + 1; e.bsy = 1'b1; e.rdy = 1'b0;
            end_at = done_at + 2;
        end
        expq.push_back(e);
        while (cyc < end_at) begin
            @(negedge clk);
            c = cyc;
            cmd_valid = (c >= a + 5 && c <= a + 8) ? 1'($urandom_range(1)) : 1'b0;
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (c < a + 36 + PT_B) begin
                core_ready = 1'($urandom_range(1));
                core_byte  = 8'($urandom);
            end else begin
                core_ready = (c >= base) && (c < base + nrdy);
                core_byte  = core_ready ? src[c - base] : 8'($urandom);
            end
            core_done = (c == done_at);
        end
        cmd_valid = 1'b0; core_ready = 1'b0; core_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, n;
        logic [63:0]  p;
        int           a, nr, md;
        rst = 1'b1; cmd_valid = 1'b0; key = 128'h0; nonce = 128'h0; pt = 64'h0;
        core_ready = 1'b0; core_done = 1'b0; core_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 128'(cmd_ready), 128'h1);
        check("rst_outs", 128'({core_start, core_valid, result_valid, err_timeout, busy}), 128'h0);
        check("rst_core_data", 128'(core_data), 128'h0);
        check("rst_result", result, 128'h0);
        check("rst_result_cnt", 128'(result_cnt), 128'h0);
        rst = 1'b0;
        @(negedge clk);

        // byte order with 16 collected bytes A0..AF, done one cycle after the last
        for (int i = 0; i < 16; i++) begin
            k[8*i +: 8] = 8'(i);
            n[8*i +: 8] = 8'(i + 16);
            src[i]      = 8'(8'hA0 + i);
        end
        for (int i = 0; i < 8; i++) p[8*i +: 8] = 8'(i + 32);
        run_cmd(k, n, p, 16, 0, 1);

        // 18 ready bytes, done together with byte 18
        for (int i = 0; i < 32; i++) src[i] = 8'($urandom);
        run_cmd({$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()}, 18, 1, 0);

        // timeout with partial bytes, then an immediate new command
        run_cmd({$urandom(), $urandom(), $urandom(), $urandom()},
                {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()}, 5, 2, 2);

        // reset during NONCE
        a = cyc;
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        n = {$urandom(), $urandom(), $urandom(), $urandom()};
        p = {$urandom(), $urandom()};
        key = k; nonce = n; pt = p; cmd_valid = 1'b1;
        push_stream(a, k, n, p, 20);
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cyc < a + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cmd_ready", 128'(cmd_ready), 128'h1);
        check("midrst_outs", 128'({core_start, core_valid, result_valid, err_timeout, busy}), 128'h0);
        check("midrst_result_cnt", 128'(result_cnt), 128'h0);
        run_cmd(k, n, p, 16, 0, 1);

        // randomized commands
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) src[i] = 8'($urandom);
            md = $urandom_range(2);
            nr = (md == 0) ? $urandom_range(20, 1) : $urandom_range(20);
            run_cmd({$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()}, {$urandom(), $urandom()},
                    nr, $urandom_range(3), md);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", 128'(expq.size()), 128'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
